// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared sizes, FSM state type and round-robin search for rr_arbiter8
package rr_arbiter8_pkg;
  localparam int NREQ = 8;
  localparam int IDXW = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDXW-1:0] last);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] k;
    dbl = {r, r} >> (last + 1'b1);
    rot = dbl[NREQ-1:0];
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) k = IDXW'(i);
    return last + 1'b1 + k;
  endfunction
endpackage

// File: rtl/rr_arbiter8_decoder3x8.sv
// decoder3x8: 3-to-8 one-hot decoder (sel in; out one-hot)
module decoder3x8 (
  input  logic [2:0] sel,
  output logic [7:0] out
);
  assign out = 8'b1 << sel;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter (clk, rst, req in; gnt, gnt_idx, gnt_valid, preempt out) with hold-until-release and optional MAX_HOLD preemption
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 0,
  parameter int HCW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);
  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d, last_q, last_d, win;
  logic [HCW-1:0] hold_q, hold_d;
  logic pre_q, pre_d, expire;
  logic [NREQ-1:0] own_oh, others;
  decoder3x8 u_dec (.sel(idx_q), .out(own_oh));
  assign others = req & ~own_oh;
  assign expire = (MAX_HOLD != 0) && (hold_q == HCW'(MAX_HOLD - 1));
  assign win = rr_pick(state_q == ST_GRANT ? others : req, last_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      last_q <= '1;
      hold_q <= '0;
      pre_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      hold_q <= hold_d;
      pre_q <= pre_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    hold_d = hold_q;
    pre_d = 1'b0;
    if (state_q == ST_IDLE ? |req : (!req[idx_q] || (expire && |others))) begin
      if (state_q == ST_IDLE || |others) begin
        state_d = ST_GRANT;
        idx_d = win;
        last_d = win;
        hold_d = '0;
        pre_d = state_q == ST_GRANT && req[idx_q];
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_GRANT) begin
      hold_d = (expire || &hold_q) ? hold_q : hold_q + 1'b1;
    end
  end
  always_comb begin
    gnt = own_oh & {NREQ{state_q == ST_GRANT}};
    gnt_idx = idx_q;
    gnt_valid = state_q == ST_GRANT;
    preempt = pre_q;
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: table-driven directed sequences plus randomized run against a behavioural model
module tb_rr_arbiter8;
  localparam int MH = 4;
  localparam int BOUND = 8 * (MH + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid, preempt;
  int n_pass = 0, n_total = 0;
  rr_arbiter8 #(.MAX_HOLD(MH), .HCW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic valid;
    logic pre;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(logic r, logic [7:0] q, logic [7:0] g, logic [2:0] i, logic v, logic p);
    vec_t e;
    e.rst = r; e.req = q; e.gnt = g; e.idx = i; e.valid = v; e.pre = p;
    tbl.push_back(e);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  function automatic int rr_find(logic [7:0] r, int last);
    for (int j = 1; j <= 8; j++) if (r[(last + j) % 8]) return (last + j) % 8;
    return -1;
  endfunction
  int m_own = -1, m_last = 7, m_hold = 0;
  bit m_pre = 0;
  always @(posedge clk) begin
    automatic int pick;
    automatic logic [7:0] oth;
    automatic bit rel, exp_hold;
    m_pre = 0;
    if (rst) begin
      m_own = -1; m_last = 7; m_hold = 0;
    end else if (m_own < 0) begin
      pick = rr_find(req, m_last);
      if (pick >= 0) begin m_own = pick; m_last = pick; m_hold = 0; end
    end else begin
      oth = req;
      oth[m_own] = 1'b0;
      rel = !req[m_own];
      exp_hold = MH != 0 && m_hold >= MH - 1;
      if (rel || (exp_hold && oth != 0)) begin
        pick = rr_find(oth, m_last);
        if (pick >= 0) begin
          m_pre = !rel; m_own = pick; m_last = pick; m_hold = 0;
        end else m_own = -1;
      end else if (!exp_hold && m_hold < 255) m_hold++;
    end
  end
  int waits[8];
  initial begin
    add(1, 8'hFF, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 8'h01, 0, 1, 0);
    for (int k = 0; k < 13; k++)
      add(0, ~(8'h01 << (k % 8)), 8'h01 << ((k + 1) % 8), 3'((k + 1) % 8), 1, 0);
    add(0, 8'h05, 8'h01, 0, 1, 0);
    add(0, 8'h04, 8'h04, 2, 1, 0);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 8'h08, 8'h08, 3, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 8'h48, 8'h08, 3, 1, 0);
    add(0, 8'h48, 8'h40, 6, 1, 1);
    add(0, 8'h48, 8'h40, 6, 1, 0);
    add(0, 8'h08, 8'h08, 3, 1, 0);
    for (int k = 0; k < 6; k++) add(0, 8'h08, 8'h08, 3, 1, 0);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 8'h10, 8'h10, 4, 1, 0);
    add(0, 8'h10, 8'h10, 4, 1, 0);
    add(1, 8'h10, 8'h00, 0, 0, 0);
    add(0, 8'h30, 8'h10, 4, 1, 0);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    foreach (tbl[n]) begin
      rst = tbl[n].rst;
      req = tbl[n].req;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gnt", n), gnt, tbl[n].gnt);
      chk($sformatf("vec%0d_valid", n), gnt_valid, tbl[n].valid);
      chk($sformatf("vec%0d_preempt", n), preempt, tbl[n].pre);
      if (tbl[n].valid) chk($sformatf("vec%0d_idx", n), gnt_idx, tbl[n].idx);
    end
    foreach (waits[i]) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      rst = $urandom_range(1499) == 0;
      for (int i = 0; i < 8; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      @(posedge clk);
      #1;
      chk("rnd_gnt", gnt, m_own >= 0 ? 8'h01 << m_own : 8'h00);
      chk("rnd_valid", gnt_valid, m_own >= 0);
      chk("rnd_preempt", preempt, m_pre);
      if (m_own >= 0) chk("rnd_idx", gnt_idx, m_own);
      chk("rnd_onehot", $onehot0(gnt), 1);
      for (int i = 0; i < 8; i++)
        waits[i] = (rst || !req[i] || gnt[i]) ? 0 : waits[i] + 1;
      for (int i = 0; i < 8; i++) if (waits[i] > BOUND) begin
        chk($sformatf("starve%0d", i), waits[i], BOUND);
        waits[i] = 0;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
